instr_reg_sched: RTL and testbench

//  Scheduler/controller for the 32-entry instruction register. Arbitrates two instruction

---
 rtl/instr_register_pkg.sv | 20 ++
 rtl/instr_reg_sched_if.sv | 53 +++++
 rtl/instr_reg_sched_arb.sv | 38 +++
 rtl/instr_reg_sched.sv | 117 +++++++++++
 tb/tb_instr_reg_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its scheduler: opcode/operand/instruction
// words, the scheduler state encoding and the register depth.
package instr_register_pkg;

    localparam int SCHED_DEPTH = 32;
    localparam int SCHED_PTR_W = $clog2(SCHED_DEPTH);

    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_t;

endpackage

// File: rtl/instr_reg_sched_if.sv
// Bundle of producer, register-port and issue-port signals around the scheduler.
// master = scheduler side, slave = producers/register/consumer side.
interface instr_reg_sched_if
    import instr_register_pkg::*;
#(
    parameter int DEPTH = SCHED_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) ();

    logic              req0_valid;
    logic              req0_ready;
    opcode_t           req0_opcode;
    operand_t          req0_operand_a;
    operand_t          req0_operand_b;
    logic              req1_valid;
    logic              req1_ready;
    opcode_t           req1_opcode;
    operand_t          req1_operand_a;
    operand_t          req1_operand_b;
    logic              load_en;
    logic [PTR_W-1:0]  write_pointer;
    opcode_t           opcode;
    operand_t          operand_a;
    operand_t          operand_b;
    logic [PTR_W-1:0]  read_pointer;
    instruction_t      instruction_word;
    logic              issue_valid;
    logic              issue_ready;
    instruction_t      issue_word;
    logic              flush;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;

    modport master (
        input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        input  instruction_word, issue_ready, flush,
        output req0_ready, req1_ready,
        output load_en, write_pointer, opcode, operand_a, operand_b,
        output read_pointer, issue_valid, issue_word, count, full, empty
    );

    modport slave (
        output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        output instruction_word, issue_ready, flush,
        input  req0_ready, req1_ready,
        input  load_en, write_pointer, opcode, operand_a, operand_b,
        input  read_pointer, issue_valid, issue_word, count, full, empty
    );

endinterface

// File: rtl/instr_reg_sched_arb.sv
// Two-way arbiter for the scheduler's producers. Round-robin by default; with
// SCHED_FIXED_PRIO_EN defined req[0] always wins and the design is purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
`ifndef SCHED_FIXED_PRIO_EN
    input  logic       clk,
    input  logic       reset_n,
    input  logic       accept,
`endif
    output logic [1:0] gnt
);

`ifdef SCHED_FIXED_PRIO_EN
    assign gnt = {req[1] & ~req[0], req[0]};
`else
    // prio names the producer that wins the next tie; it moves only when a grant is used
    logic prio;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= gnt[0];
        end
    end
`endif

endmodule

// File: rtl/instr_reg_sched.sv
// Scheduler for the 32-entry instruction register: arbitrates two producers onto the write
// port and runs the register as a circular queue. Optional macro: SCHED_FIXED_PRIO_EN.
module instr_reg_sched
    import instr_register_pkg::*;
#(
    parameter int DEPTH = SCHED_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    instr_reg_sched_if.master bus
);

    sched_state_t     state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             load_en_q;
    logic [PTR_W-1:0] wp_q;
    opcode_t          opc_q;
    operand_t         a_q;
    operand_t         b_q;

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [PTR_W+1:0] occupancy;
    logic             can_accept;
    logic             accept;
    logic             issue_valid;
    logic             pop;

    assign req = {bus.req1_valid, bus.req0_valid};

    // A write already in flight still needs a slot, so it counts against the free space
    assign occupancy   = {1'b0, cnt} + {{(PTR_W+1){1'b0}}, load_en_q};
    assign can_accept  = reset_n && (state != FLUSH) && !bus.flush
                         && (occupancy < (PTR_W+2)'(DEPTH));
    assign accept      = can_accept && (|req);
    assign issue_valid = (state == RUN) && (cnt != '0);
    assign pop         = issue_valid && bus.issue_ready;

`ifdef SCHED_FIXED_PRIO_EN
    rr_arb2 u_arb (
        .req (req),
        .gnt (gnt)
    );
`else
    rr_arb2 u_arb (
        .req     (req),
        .clk     (clk),
        .reset_n (reset_n),
        .accept  (accept),
        .gnt     (gnt)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            load_en_q <= 1'b0;
            wp_q      <= '0;
            opc_q     <= ZERO;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            load_en_q <= accept;
            if (accept) begin
                wp_q   <= wr_ptr;
                wr_ptr <= wr_ptr + PTR_W'(1);
                opc_q  <= gnt[1] ? bus.req1_opcode    : bus.req0_opcode;
                a_q    <= gnt[1] ? bus.req1_operand_a : bus.req0_operand_a;
                b_q    <= gnt[1] ? bus.req1_operand_b : bus.req0_operand_b;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({load_en_q, pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: ;
            endcase
            // FLUSH's pointer/count clear overrides the bookkeeping above
            unique case (state)
                IDLE:    if (accept) state <= RUN;
                RUN:     if (cnt == '0 && !load_en_q && !accept) state <= IDLE;
                FLUSH: begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (bus.flush) begin
                state <= FLUSH;
            end
        end
    end

    assign bus.req0_ready    = can_accept && gnt[0];
    assign bus.req1_ready    = can_accept && gnt[1];
    assign bus.load_en       = load_en_q;
    assign bus.write_pointer = wp_q;
    assign bus.opcode        = opc_q;
    assign bus.operand_a     = a_q;
    assign bus.operand_b     = b_q;
    assign bus.read_pointer  = rd_ptr;
    assign bus.issue_valid   = issue_valid;
    assign bus.issue_word    = bus.instruction_word;
    assign bus.count         = cnt;
    assign bus.full          = (cnt == (PTR_W+1)'(DEPTH));
    assign bus.empty         = (cnt == '0);

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched with a behavioural 32-entry instruction register.
module tb_instr_reg_sched;
    import instr_register_pkg::*;

    typedef struct {
        opcode_t  opc;
        operand_t a;
        operand_t b;
        int       exp_wp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    instr_reg_sched_if ifc ();

    instr_reg_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.master)
    );

    // Behavioural instruction register: sampled on posedge, read combinationally
    instruction_t mem [SCHED_DEPTH];
    always @(posedge clk) begin
        if (ifc.load_en) mem[ifc.write_pointer] <= {ifc.opcode, ifc.operand_a, ifc.operand_b};
    end
    assign ifc.instruction_word = mem[ifc.read_pointer];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input instruction_t act, input instruction_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int port, input logic valid, input opcode_t opc,
                                  input operand_t a, input operand_t b);
        if (port == 0) begin
            ifc.req0_valid = valid; ifc.req0_opcode = opc;
            ifc.req0_operand_a = a; ifc.req0_operand_b = b;
        end else begin
            ifc.req1_valid = valid; ifc.req1_opcode = opc;
            ifc.req1_operand_a = a; ifc.req1_operand_b = b;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply_stimulus(0, 1'b0, ZERO, 0, 0);
        apply_stimulus(1, 1'b0, ZERO, 0, 0);
        ifc.issue_ready = 1'b0;
        ifc.flush = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    function automatic instruction_t wdata();
        return {ifc.opcode, ifc.operand_a, ifc.operand_b};
    endfunction

    vec_t single_vec [11];
    int   exp_gnt [6];

    initial begin
        single_vec[0]  = '{ADD,   5,   3, 0};
        single_vec[1]  = '{SUB,   9,   4, 1};
        single_vec[2]  = '{MULT,  7,   6, 2};
        single_vec[3]  = '{DIV,  40,   8, 3};
        single_vec[4]  = '{MOD,  17,   5, 4};
        single_vec[5]  = '{PASSA, 1,   0, 5};
        single_vec[6]  = '{PASSB, 0,  12, 6};
        single_vec[7]  = '{ZERO,  0,   0, 7};
        single_vec[8]  = '{ADD,  -3,  11, 8};
        single_vec[9]  = '{SUB, 100, -50, 9};
        single_vec[10] = '{MULT, -2,  -2, 10};
`ifdef SCHED_FIXED_PRIO_EN
        exp_gnt = '{0, 0, 0, 0, 0, 0};
`else
        exp_gnt = '{0, 1, 0, 1, 0, 1};
`endif

        // Reset values
        do_reset();
        reset_n = 1'b0;
        tick();
        check_output("rst_load_en", int'(ifc.load_en), 0);
        check_output("rst_count", int'(ifc.count), 0);
        check_output("rst_empty", int'(ifc.empty), 1);
        check_output("rst_issue_valid", int'(ifc.issue_valid), 0);
        check_output("rst_read_pointer", int'(ifc.read_pointer), 0);
        check_output("rst_full", int'(ifc.full), 0);
        reset_n = 1'b1;

        // Single producer: 11 writes back to back, then drain in order
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(0, 1'b1, single_vec[i].opc, single_vec[i].a, single_vec[i].b);
            #1;
            check_output("sp_ready", int'(ifc.req0_ready), 1);
            if (i == 0) check_output("sp_load_before", int'(ifc.load_en), 0);
            tick();
            check_output("sp_load_en", int'(ifc.load_en), 1);
            check_output("sp_write_pointer", int'(ifc.write_pointer), single_vec[i].exp_wp);
            check_word("sp_wdata", wdata(), {single_vec[i].opc, single_vec[i].a, single_vec[i].b});
        end
        apply_stimulus(0, 1'b0, ZERO, 0, 0);
        tick();
        check_output("sp_count", int'(ifc.count), 11);
        check_output("sp_load_idle", int'(ifc.load_en), 0);
        for (int j = 0; j < 11; j++) begin
            ifc.issue_ready = 1'b1;
            #1;
            check_output("sp_issue_valid", int'(ifc.issue_valid), 1);
            check_output("sp_read_pointer", int'(ifc.read_pointer), j);
            check_word("sp_issue_word", ifc.issue_word,
                       {single_vec[j].opc, single_vec[j].a, single_vec[j].b});
            tick();
        end
        ifc.issue_ready = 1'b0;
        check_output("sp_drained_count", int'(ifc.count), 0);
        check_output("sp_drained_valid", int'(ifc.issue_valid), 0);

        // Contention: both producers hold valid for 6 cycles
        do_reset();
        apply_stimulus(0, 1'b1, SUB, 10, 20);
        apply_stimulus(1, 1'b1, MULT, 30, 40);
        for (int k = 0; k < 6; k++) begin
            #1;
            check_output("ct_ready0", int'(ifc.req0_ready), exp_gnt[k] == 0 ? 1 : 0);
            check_output("ct_ready1", int'(ifc.req1_ready), exp_gnt[k] == 1 ? 1 : 0);
            tick();
            check_word("ct_wdata", wdata(), exp_gnt[k] == 0 ? {SUB, 32'sd10, 32'sd20}
                                                            : {MULT, 32'sd30, 32'sd40});
        end

        // Full and wrap: 32 writes fill the queue, the 33rd is held until one pop
        do_reset();
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(0, 1'b1, ADD, i, 1);
            #1;
            check_output("fw_ready", int'(ifc.req0_ready), 1);
            tick();
        end
        apply_stimulus(0, 1'b1, ADD, 32, 1);
        apply_stimulus(1, 1'b1, SUB, 99, 99);
        #1;
        check_output("fw_hold_ready0", int'(ifc.req0_ready), 0);
        check_output("fw_hold_ready1", int'(ifc.req1_ready), 0);
        tick();
        check_output("fw_count_full", int'(ifc.count), 32);
        check_output("fw_full", int'(ifc.full), 1);
        check_output("fw_full_ready0", int'(ifc.req0_ready), 0);
        check_output("fw_full_ready1", int'(ifc.req1_ready), 0);
        apply_stimulus(1, 1'b0, ZERO, 0, 0);
        tick();
        check_output("fw_no_load", int'(ifc.load_en), 0);
        ifc.issue_ready = 1'b1;
        #1;
        check_word("fw_pop_word", ifc.issue_word, {ADD, 32'sd0, 32'sd1});
        tick();
        ifc.issue_ready = 1'b0;
        #1;
        check_output("fw_held_ready", int'(ifc.req0_ready), 1);
        tick();
        apply_stimulus(0, 1'b0, ZERO, 0, 0);
        check_output("fw_wrap_load", int'(ifc.load_en), 1);
        check_output("fw_wrap_wp", int'(ifc.write_pointer), 0);
        check_output("fw_wrap_a", int'(ifc.operand_a), 32);
        tick();
        check_output("fw_wrap_count", int'(ifc.count), 32);

        // Simultaneous commit and pop at count 4
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 1'b1, ADD, 40 + i, 2);
            tick();
        end
        apply_stimulus(0, 1'b0, ZERO, 0, 0);
        tick();
        check_output("sim_count_pre", int'(ifc.count), 4);
        apply_stimulus(0, 1'b1, SUB, 44, 2);
        tick();
        apply_stimulus(0, 1'b0, ZERO, 0, 0);
        ifc.issue_ready = 1'b1;
        #1;
        check_output("sim_load_en", int'(ifc.load_en), 1);
        check_output("sim_read_pointer", int'(ifc.read_pointer), 0);
        check_word("sim_pop_word", ifc.issue_word, {ADD, 32'sd40, 32'sd2});
        tick();
        ifc.issue_ready = 1'b0;
        check_output("sim_count_post", int'(ifc.count), 4);
        check_output("sim_read_pointer_post", int'(ifc.read_pointer), 1);

        // Flush with a write pending, then reset during a pending write
        do_reset();
        apply_stimulus(0, 1'b1, MOD, 60, 7);
        tick();
        apply_stimulus(0, 1'b0, ZERO, 0, 0);
        apply_stimulus(1, 1'b1, DIV, 70, 7);
        ifc.flush = 1'b1;
        #1;
        check_output("fl_pending_load", int'(ifc.load_en), 1);
        check_output("fl_prio_ready1", int'(ifc.req1_ready), 0);
        tick();
        ifc.flush = 1'b0;
        #1;
        check_output("fl_state_ready1", int'(ifc.req1_ready), 0);
        check_output("fl_state_issue", int'(ifc.issue_valid), 0);
        check_output("fl_state_load", int'(ifc.load_en), 0);
        tick();
        check_output("fl_count", int'(ifc.count), 0);
        check_output("fl_empty", int'(ifc.empty), 1);
        check_output("fl_read_pointer", int'(ifc.read_pointer), 0);
        check_output("fl_idle_ready1", int'(ifc.req1_ready), 1);
        tick();
        apply_stimulus(1, 1'b0, ZERO, 0, 0);
        check_output("fl_after_load", int'(ifc.load_en), 1);
        check_output("fl_after_wp", int'(ifc.write_pointer), 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_output("rm_load_en", int'(ifc.load_en), 0);
        check_output("rm_count", int'(ifc.count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
